// File: rtl/vga_bus_arbiter.sv
// ---------------------------------------------------------------------------
// vga_bus_arbiter
//   Two-master / one-slave Wishbone arbiter in front of the text display RAM.
//   Master 0 is the scanline fetcher (hard real-time, normally wins).
//   Master 1 is the CPU/host port. It is guaranteed a slot after VID_BURST
//   consecutive video acks taken while it was waiting.
//   A hung slave cycle is aborted after TIMEOUT owned cycles with a one-cycle
//   err pulse to the owner.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   m0_*                video master Wishbone port (cyc/stb/we/sel/adr/dat)
//   m1_*                CPU master Wishbone port (same set)
//   s_*                 shared slave Wishbone port
//   gnt                 one-hot current owner {m1, m0}; 00 = idle
// ---------------------------------------------------------------------------
module vga_bus_arbiter #(
    parameter int VID_BURST = 16,
    parameter int TIMEOUT   = 64,
    parameter int AW        = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // video master
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [AW-1:0] m0_adr,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack,
    output logic          m0_err,
    // CPU master
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [AW-1:0] m1_adr,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack,
    output logic          m1_err,
    // slave
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [3:0]    s_sel,
    output logic [AW-1:0] s_adr,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack,
    // status
    output logic [1:0]    gnt
);

    localparam int BW = $clog2(VID_BURST + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(VID_BURST);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          req0, req1;
    logic          owned;
    logic          own_cyc, own_stb, own_we;
    logic [3:0]    own_sel;
    logic [AW-1:0] own_adr;
    logic [31:0]   own_dat;
    logic          tmo_hit;
    logic          ack_hit;

    assign req0  = m0_cyc & m0_stb;
    assign req1  = m1_cyc & m1_stb;
    assign owned = (state_q != S_IDLE);

    // Owner's request fields; all zero while idle so the slave port rests at 0.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        if (state_q == S_VID) begin
            own_cyc = m0_cyc;
            own_stb = m0_stb;
            own_we  = m0_we;
            own_sel = m0_sel;
            own_adr = m0_adr;
            own_dat = m0_dat_i;
        end else if (state_q == S_CPU) begin
            own_cyc = m1_cyc;
            own_stb = m1_stb;
            own_we  = m1_we;
            own_sel = m1_sel;
            own_adr = m1_adr;
            own_dat = m1_dat_i;
        end
    end

    // An ack arriving on the last allowed cycle still completes the transfer,
    // and a master that already dropped cyc never sees ack or err.
    assign tmo_hit = owned & own_cyc & ~s_ack & (tmo_cnt_q == TMO_LAST);
    assign ack_hit = owned & own_cyc & s_ack;

    // Slave-side and master-side outputs, purely combinational from state.
    always_comb begin
        s_cyc    = own_cyc & ~tmo_hit;
        s_stb    = own_stb & ~tmo_hit;
        s_we     = own_we;
        s_sel    = own_sel;
        s_adr    = own_adr;
        s_dat_o  = own_dat;

        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_o = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_o = '0;

        if (state_q == S_VID) begin
            m0_ack   = ack_hit;
            m0_err   = tmo_hit;
            m0_dat_o = s_ack ? s_dat_i : '0;
        end else if (state_q == S_CPU) begin
            m1_ack   = ack_hit;
            m1_err   = tmo_hit;
            m1_dat_o = s_ack ? s_dat_i : '0;
        end

        gnt = {state_q == S_CPU, state_q == S_VID};
    end

    // Next-state, burst and timeout counters.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                // Video wins unless the CPU has already waited through a full burst.
                if (req0 && !(req1 && (burst_cnt_q == BURST_MAX))) begin
                    state_d = S_VID;
                end else if (req1) begin
                    state_d     = S_CPU;
                    burst_cnt_d = '0;
                end
            end

            S_VID, S_CPU: begin
                if (!own_cyc || s_ack || tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end

                // Count only video acks that happened while the CPU was waiting.
                if ((state_q == S_VID) && ack_hit) begin
                    if (req1) begin
                        if (burst_cnt_q != BURST_MAX) begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                        end
                    end else begin
                        burst_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_bus_arbiter
//   Self-checking bench: directed scenarios plus randomized master/slave
//   traffic, all outputs compared every cycle against a reference model that
//   tracks owner / owned-cycle count / video streak as plain integers.
// ---------------------------------------------------------------------------
module tb_vga_bus_arbiter;

    localparam int VB = 16;
    localparam int TO = 64;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_cyc, m0_stb, m0_we;
    logic [3:0]    m0_sel;
    logic [AW-1:0] m0_adr;
    logic [31:0]   m0_dat_i, m0_dat_o;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [3:0]    m1_sel;
    logic [AW-1:0] m1_adr;
    logic [31:0]   m1_dat_i, m1_dat_o;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_dat_o, s_dat_i;
    logic          s_ack;
    logic [1:0]    gnt;

    always #5 clk_i = ~clk_i;

    vga_bus_arbiter #(.VID_BURST(VB), .TIMEOUT(TO), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .gnt(gnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mown: 0 = nobody, 1 = video master, 2 = CPU master
    int mown   = 0;
    int mtmo   = 0;   // owned cycles already spent without ack
    int mburst = 0;   // video acks granted while CPU waited

    logic        e_oc, e_to;
    logic        e_s_cyc, e_s_stb, e_s_we;
    logic [3:0]  e_s_sel;
    logic [31:0] e_s_adr, e_s_dat;
    logic        e_m0_ack, e_m0_err, e_m1_ack, e_m1_err;
    logic [31:0] e_m0_dat, e_m1_dat;
    logic [1:0]  e_gnt;

    task automatic model_out();
        logic os, ow;
        logic [3:0] osel;
        logic [31:0] oadr, odat;
        e_oc = 1'b0; os = 1'b0; ow = 1'b0; osel = '0; oadr = '0; odat = '0;
        if (mown == 1) begin
            e_oc = m0_cyc; os = m0_stb; ow = m0_we; osel = m0_sel; oadr = m0_adr; odat = m0_dat_i;
        end else if (mown == 2) begin
            e_oc = m1_cyc; os = m1_stb; ow = m1_we; osel = m1_sel; oadr = m1_adr; odat = m1_dat_i;
        end
        e_to     = (mown != 0) && e_oc && !s_ack && (mtmo == TO - 1);
        e_s_cyc  = e_oc && !e_to;
        e_s_stb  = os && !e_to;
        e_s_we   = ow;
        e_s_sel  = osel;
        e_s_adr  = oadr;
        e_s_dat  = odat;
        e_m0_ack = (mown == 1) && e_oc && s_ack;
        e_m1_ack = (mown == 2) && e_oc && s_ack;
        e_m0_err = (mown == 1) && e_to;
        e_m1_err = (mown == 2) && e_to;
        e_m0_dat = (mown == 1 && s_ack) ? s_dat_i : 32'h0;
        e_m1_dat = (mown == 2 && s_ack) ? s_dat_i : 32'h0;
        e_gnt    = (mown == 1) ? 2'b01 : (mown == 2) ? 2'b10 : 2'b00;
    endtask

    task automatic model_upd();
        bit r0, r1;
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        if (rst_i) begin
            mown = 0; mtmo = 0; mburst = 0;
        end else if (mown == 0) begin
            mtmo = 0;
            if (r0 && !(r1 && mburst == VB)) mown = 1;
            else if (r1) begin mown = 2; mburst = 0; end
        end else begin
            if (e_m0_ack) mburst = r1 ? ((mburst < VB) ? mburst + 1 : VB) : 0;
            if (!e_oc || s_ack || e_to) mown = 0;
            else mtmo++;
        end
    endtask

    // Settle after the falling edge, then compare every output to the model.
    task automatic eval();
        #1;
        model_out();
        chk("s_cyc",    32'(s_cyc),    32'(e_s_cyc));
        chk("s_stb",    32'(s_stb),    32'(e_s_stb));
        chk("s_we",     32'(s_we),     32'(e_s_we));
        chk("s_sel",    32'(s_sel),    32'(e_s_sel));
        chk("s_adr",    s_adr,         e_s_adr);
        chk("s_dat_o",  s_dat_o,       e_s_dat);
        chk("m0_ack",   32'(m0_ack),   32'(e_m0_ack));
        chk("m0_err",   32'(m0_err),   32'(e_m0_err));
        chk("m0_dat_o", m0_dat_o,      e_m0_dat);
        chk("m1_ack",   32'(m1_ack),   32'(e_m1_ack));
        chk("m1_err",   32'(m1_err),   32'(e_m1_err));
        chk("m1_dat_o", m1_dat_o,      e_m1_dat);
        chk("gnt",      32'(gnt),      32'(e_gnt));
    endtask

    task automatic adv();
        @(posedge clk_i);
        model_upd();
        @(negedge clk_i);
    endtask

    task automatic clr_in();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat_i = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat_i = '0;
        s_ack = 0; s_dat_i = '0;
    endtask

    task automatic do_rst();
        rst_i = 1'b1;
        clr_in();
        eval();
        adv();
        rst_i = 1'b0;
    endtask

    task automatic m0_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc = 1; m0_stb = 1; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat_i = dat;
    endtask

    task automatic m1_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = 1; m1_stb = 1; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat_i = dat;
    endtask

    initial begin
        int q[$];
        int na0, own, err_at, nerr, nack;
        bit done, a0, a1;
        int p_ack;

        rst_i = 1'b1;
        clr_in();
        repeat (2) @(negedge clk_i);

        // ---- reset state ----
        eval();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_m0dat", m0_dat_o, 32'h0);
        adv();
        rst_i = 1'b0;

        // ---- single read ----
        do_rst();
        m0_req(1'b0, 32'h0000_00A0, 32'h0);
        eval(); chk("rd_idle_scyc", 32'(s_cyc), 32'h0); adv();
        eval(); chk("rd_gnt", 32'(gnt), 32'h1); chk("rd_scyc", 32'(s_cyc), 32'h1);
        chk("rd_adr", s_adr, 32'h0000_00A0); adv();
        eval(); adv();
        s_ack = 1; s_dat_i = 32'h1234_5678;
        eval(); chk("rd_ack", 32'(m0_ack), 32'h1); chk("rd_dat", m0_dat_o, 32'h1234_5678);
        chk("rd_m1ack", 32'(m1_ack), 32'h0); adv();
        clr_in();
        eval(); chk("rd_gnt_idle", 32'(gnt), 32'h0); adv();

        // ---- simultaneous request ----
        do_rst();
        m0_req(1'b0, 32'h0000_0020, 32'h0);
        m1_req(1'b1, 32'h0000_0010, 32'hCAFE_0041);
        eval(); adv();
        s_ack = 1;
        eval(); chk("sim_gnt0", 32'(gnt), 32'h1); chk("sim_m0ack", 32'(m0_ack), 32'h1);
        chk("sim_m1ack0", 32'(m1_ack), 32'h0); adv();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        eval(); chk("sim_idle", 32'(gnt), 32'h0); adv();
        s_ack = 1;
        eval(); chk("sim_gnt1", 32'(gnt), 32'h2); chk("sim_adr", s_adr, 32'h0000_0010);
        chk("sim_dat", s_dat_o, 32'hCAFE_0041); chk("sim_sel", 32'(s_sel), 32'hF);
        chk("sim_we", 32'(s_we), 32'h1); chk("sim_m1ack", 32'(m1_ack), 32'h1); adv();
        clr_in(); eval(); adv();

        // ---- starvation ----
        do_rst();
        m0_req(1'b0, 32'h100, 32'h0);
        m1_req(1'b0, 32'h200, 32'h0);
        s_ack = 1; s_dat_i = 32'h55AA_55AA;
        na0 = 0;
        for (int i = 0; i < 200 && q.size() < 2; i++) begin
            eval();
            if (m0_ack) na0++;
            if (m1_ack) begin q.push_back(na0); na0 = 0; end
            adv();
        end
        chk("starve_m1_slots", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            chk("starve_burst1", 32'(q[0]), 32'd16);
            chk("starve_burst2", 32'(q[1]), 32'd16);
        end
        clr_in(); eval(); adv();

        // ---- timeout ----
        do_rst();
        m1_req(1'b0, 32'h40, 32'h0);
        own = 0; err_at = 0; nerr = 0; nack = 0; done = 0;
        for (int i = 0; i < 150 && !done; i++) begin
            eval();
            if (gnt == 2'b10) own++;
            if (m1_ack) nack++;
            if (m1_err) begin
                nerr++; err_at = own;
                chk("to_scyc", 32'(s_cyc), 32'h0);
                done = 1;
            end
            adv();
        end
        clr_in();
        eval(); chk("to_idle", 32'(gnt), 32'h0); adv();
        chk("to_at", 32'(err_at), 32'd64);
        chk("to_nerr", 32'(nerr), 32'd1);
        chk("to_noack", 32'(nack), 32'd0);

        // ---- abort by dropping cyc ----
        do_rst();
        m0_req(1'b0, 32'h80, 32'h0);
        eval(); adv();
        eval(); chk("ab_gnt", 32'(gnt), 32'h1); adv();
        m0_cyc = 0; m0_stb = 0; s_ack = 1;
        eval(); chk("ab_ack", 32'(m0_ack), 32'h0); chk("ab_err", 32'(m0_err), 32'h0); adv();
        s_ack = 0;
        eval(); chk("ab_idle", 32'(gnt), 32'h0); adv();

        // ---- ack on the timeout cycle ----
        do_rst();
        m0_req(1'b0, 32'hC0, 32'h0);
        eval(); adv();
        for (int i = 0; i < TO - 1; i++) begin eval(); adv(); end
        s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
        eval(); chk("race_ack", 32'(m0_ack), 32'h1); chk("race_err", 32'(m0_err), 32'h0); adv();
        clr_in(); eval(); adv();

        // ---- reset mid-transaction ----
        do_rst();
        m1_req(1'b1, 32'h44, 32'h1111_2222);
        eval(); adv();
        rst_i = 1; s_ack = 1;
        eval(); adv();
        rst_i = 0; clr_in();
        eval(); chk("mr_gnt", 32'(gnt), 32'h0); chk("mr_scyc", 32'(s_cyc), 32'h0);
        chk("mr_m1ack", 32'(m1_ack), 32'h0); adv();
        m0_req(1'b0, 32'h48, 32'h0);
        eval(); adv();
        eval(); chk("mr_regrant", 32'(gnt), 32'h1); adv();
        clr_in(); eval(); adv();

        // ---- randomized traffic ----
        a0 = 0; a1 = 0;
        for (int i = 0; i < 4000; i++) begin
            case ((i / 400) % 4)
                0: p_ack = 40;
                1: p_ack = 0;
                2: p_ack = 5;
                default: p_ack = 90;
            endcase
            if (!a0 && ($urandom % 4 != 0)) begin
                a0 = 1; m0_we = 1'($urandom); m0_sel = 4'($urandom);
                m0_adr = $urandom; m0_dat_i = $urandom;
            end else if (a0 && ($urandom % 60 == 0)) a0 = 0;
            if (!a1 && ($urandom % 3 == 0)) begin
                a1 = 1; m1_we = 1'($urandom); m1_sel = 4'($urandom);
                m1_adr = $urandom; m1_dat_i = $urandom;
            end else if (a1 && ($urandom % 60 == 0)) a1 = 0;
            m0_cyc = a0; m0_stb = a0 && ($urandom % 8 != 0);
            m1_cyc = a1; m1_stb = a1 && ($urandom % 8 != 0);
            s_ack   = ($urandom % 100) < p_ack;
            s_dat_i = $urandom;
            rst_i   = ($urandom % 700 == 0);
            eval();
            if (e_m0_ack || e_m0_err) a0 = 0;
            if (e_m1_ack || e_m1_err) a1 = 0;
            adv();
        end
        rst_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_bus_arbiter.md
Name: vga_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the text display memory port.
- Master 0 is the text-mode scanline fetcher. It makes one read per character pair, about 41 reads per scanline, and has a hard real-time deadline.
- Master 1 is the CPU/host port. It reads and writes the character/colour buffer.
- The block sits between both masters and the shared text RAM slave. It grants the bus, muxes address and data, steers ack/err, and aborts hung cycles with a timeout.

Parameters:
- VID_BURST, 16, max consecutive master-0 grants while master 1 waits (anti-starvation).
- TIMEOUT, 64, slave cycles without ack before the arbiter aborts the transaction with err.
- AW, 32, address width.

Ports:
- clk_i  in  1  system/dot clock.
- rst_i  in  1  synchronous active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  video master Wishbone control.
- m0_sel  in  4  video byte selects.
- m0_adr  in  AW  video address.
- m0_dat_i  in  32  video write data.
- m0_dat_o  out  32  read data to video.
- m0_ack, m0_err  out  1 each  video termination.
- m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i, m1_dat_o, m1_ack, m1_err: same as the m0 set, for the CPU master.
- s_cyc, s_stb, s_we  out  1 each  slave control.
- s_sel  out  4  slave byte selects.
- s_adr  out  AW  slave address.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack  in  1  slave acknowledge.
- gnt  out  2  one-hot current owner; 00 = idle (debug/status).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - state = S_IDLE, gnt = 00, burst counter = 0, timeout counter = 0.
  - s_cyc = s_stb = s_we = 0. s_adr, s_sel, s_dat_o = 0.
  - All m*_ack and m*_err = 0. m*_dat_o = 0.
- Request: master n requests when mn_cyc & mn_stb.
- FSM states:
  - S_IDLE:
    - Evaluate requests; the chosen owner's state is entered on the next edge.
    - Priority: master 0 wins, unless master 1 requests and burst counter == VID_BURST; then master 1 wins.
    - Only master 1 requesting → S_CPU. No request → stay in S_IDLE.
  - S_VID / S_CPU:
    - gnt is one-hot for the owner.
    - s_cyc/s_stb/s_we/s_sel/s_adr/s_dat_o are driven combinationally from the owner's inputs.
    - s_cyc = owner_cyc and s_stb = owner_stb; the non-owner is fully ignored.
    - Owner ack = s_ack, combinational.
    - Owner dat_o = s_dat_i while s_ack is high, else 0.
    - Non-owner ack, err and dat_o = 0.
    - On s_ack → S_IDLE next edge.
    - On owner dropping cyc before ack → S_IDLE (abort); no ack or err is generated.
- Arbitration latency: at least 1 idle cycle between transactions. A request seen in S_IDLE at edge k gives s_cyc high from edge k+1.
- Burst counter:
  - Increments, saturating at VID_BURST, on each master-0 ack while m1 requests.
  - Clears to 0 on any master-1 grant.
  - Clears to 0 on a master-0 ack while m1 is not requesting.
- Timeout:
  - Counter clears on grant and increments each owned cycle without s_ack.
  - When it reaches TIMEOUT-1 without s_ack: assert owner err for exactly one cycle, force s_cyc = s_stb = 0 that cycle, ack = 0, then → S_IDLE.
- Simultaneous events:
  - s_ack on the timeout cycle: ack wins, no err.
  - s_ack with owner cyc low: ack is suppressed to the master and the FSM returns to S_IDLE.
- Reset mid-transaction: next edge is S_IDLE with all outputs at reset values, regardless of s_ack.
- Widths: counters are $clog2(VID_BURST+1) and $clog2(TIMEOUT) bits. Comparisons are unsigned.

Test Plan:
- Single read: m0 reads adr 0x0000_00A0; slave acks 2 cycles after s_cyc with 0x1234_5678 → s_cyc high 1 cycle after request, m0_ack 1 cycle, m0_dat_o = 0x1234_5678, m1_ack stays 0, gnt returns to 00.
- Simultaneous request, counter 0: m0 and m1 request in the same S_IDLE cycle → m0 granted first. m1 is granted in the S_IDLE cycle after m0's ack (one idle cycle). The m1 write (0x0000_0010, data 0xCAFE_0041, sel 0xF) reaches the slave unchanged.
- Starvation: m0 requests back-to-back and m1 holds a request → exactly 16 m0 acks, then one m1 transaction, then m0 resumes; burst counter reads 0 after the m1 grant.
- Timeout: m1 read, slave never acks → m1_err pulses 1 cycle at owned cycle 64 (TIMEOUT-1 = 63 after grant), no m1_ack, s_cyc low that cycle, state back to S_IDLE.
- Abort and ack/timeout race: m0 drops cyc 1 cycle after grant → no ack/err, S_IDLE next edge. Separately, s_ack coincident with timeout → m*_ack=1, m*_err=0.
- Reset mid-cycle: assert rst_i while S_CPU with s_ack=1 → next edge gnt=00, s_cyc=0, m1_ack=0, counters 0; a m0 request after release is granted normally.
